narnet_core: RTL and testbench
==============================

NARNET_CORE -- requirements
Module: narnet_core

Interface
REQ-001 Parameter N, default 16: sample/weight word width, signed two's complement.
REQ-002 Parameter Q, default 10: fractional bits of every word.
REQ-003 Parameter D, default 16: tap-delay depth (input taps per hidden neuron), 2..64.
REQ-004 Parameter H, default 5: hidden neuron count, 1..16.
REQ-005 Parameter INIT, default 16'sd384 (0.375): tap reset/initial value.
REQ-006 clk  in  1  clock; reset rst, synchronous, active-high; clock clk.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 in_valid  in  1 / in_ready  out  1: sample handshake; accept = both high on a rising edge.
REQ-009 x_in  in  N: new sample; mode  in  1: 0 open-loop (push x_in), 1 closed-loop (push last y_out).
REQ-010 w_addr  out  clog2(H*D+2H+1) / w_data  in  N: weight ROM port, data valid 1 cycle after address.
REQ-011 t_addr  out  N / t_data  in  N: tanh LUT port, data valid 1 cycle after address.
REQ-012 y_out  out  N: registered result; out_valid  out  1: one-cycle pulse; sat  out  1: saturation occurred this inference, valid with out_valid.

Function
REQ-013 Weight map: addr h = b1[h]; H+h*D+d = W1[h][d]; H+H*D+h = W2[h]; H+H*D+H = b2.
REQ-014 Delay line: D-entry circular buffer, tap 0 = newest; on accept the oldest tap is overwritten.
REQ-015 mode and x_in sampled only on the accept edge; closed-loop pushes current y_out register.
REQ-016 FSM states IDLE, PUSH, L1, TANH, L2, OUT; in_ready=1 only in IDLE.
REQ-017 IDLE->PUSH on accept; PUSH 1 cycle (tap write); L1 D+2 cycles per neuron (bias fetch, bias load, D MACs pipelined with ROM, store).
REQ-018 TANH 2 cycles per neuron (t_addr = saturated hidden sum, capture t_data); L2 H+2 cycles; OUT 1 cycle then IDLE.
REQ-019 out_valid SHALL pulse exactly LAT = H*D+5H+4 cycles after the accept edge (109 for defaults).
REQ-020 Products full 2N bits; accumulator 2N+clog2(D+1) bits; bias aligned by <<Q before accumulation.
REQ-021 Result = accumulator arithmetic-shifted right Q (floor), saturated to N-bit signed range; sat set if any hidden or output value clipped.
REQ-022 in_valid while not in IDLE ignored, no state change; back-to-back accept permitted in the IDLE cycle after OUT.
REQ-023 y_out, sat hold value until the next OUT state.

Reset
REQ-024 rst (any state, including mid-inference) SHALL return FSM to IDLE with no out_valid for the aborted inference.
REQ-025 Reset values: y_out=0, sat=0, out_valid=0, in_ready=1 the cycle after rst deasserts, w_addr=0, t_addr=0, all taps=INIT, write pointer=0.

Structure
REQ-026 Shared package holds FSM state enum, weight-map offset functions, and saturate/round helper.
REQ-027 One sub-module narnet_mac: shared signed MAC with clear, bias-load, enable, saturated N-bit output and clip flag.
REQ-028 Single MAC instance, time-multiplexed across all neurons; no per-neuron multipliers.

Verification (defaults N=16,Q=10,D=16,H=5; bench tanh model t_data=t_addr unless stated)
REQ-029 All weights 0, b2=512, x_in=100 -> y_out=512, out_valid exactly 109 cycles after accept, sat=0.
REQ-030 W1[0][0]=1024, W2[0]=1024, others 0, x_in=300 -> y_out=300; next accept x_in=-200 -> y_out=-200.
REQ-031 W1 all 32767, W2[0]=32767, x_in=32767 -> y_out=32767, sat=1; negated weights -> y_out=-32768, sat=1.
REQ-032 Identity net of REQ-030, first step mode=0 x_in=300, then 3 steps mode=1 -> y_out=300 each step, x_in ignored.
REQ-033 rst at cycle 50 of an inference -> no out_valid, in_ready=1 next cycle, following inference with W1[0][5]=1024 only yields INIT (384).
REQ-034 in_valid held high throughout -> exactly one accept per LAT+1 cycles, no dropped or duplicated out_valid.

Source files
------------

// File: rtl/narnet_pkg.sv
// Shared definitions for the NARNET core: FSM states, weight ROM map and
// the fixed-point shift/saturate helper used by the MAC.
package narnet_pkg;

  typedef enum logic [2:0] {StIdle, StPush, StL1, StTanh, StL2, StOut} state_e;

  // Wide enough for any supported accumulator; callers sign-extend into it.
  localparam int unsigned MaxW = 128;

  function automatic int unsigned b1_addr(input int unsigned h);
    return h;
  endfunction

  function automatic int unsigned w1_addr(input int unsigned h, input int unsigned d,
                                          input int unsigned hn, input int unsigned dn);
    return hn + h * dn + d;
  endfunction

  function automatic int unsigned w2_addr(input int unsigned h, input int unsigned hn,
                                          input int unsigned dn);
    return hn + hn * dn + h;
  endfunction

  function automatic int unsigned b2_addr(input int unsigned hn, input int unsigned dn);
    return hn + hn * dn + hn;
  endfunction

  // Floor-shift by q, then clamp to the n-bit signed range.
  function automatic logic signed [MaxW-1:0] sat_shift(input logic signed [MaxW-1:0] a,
                                                       input int unsigned n,
                                                       input int unsigned q);
    logic signed [MaxW-1:0] s;
    logic signed [MaxW-1:0] hi;
    logic signed [MaxW-1:0] lo;
    s  = a >>> q;
    hi = (MaxW'(1) << (n - 1)) - MaxW'(1);
    lo = ~hi;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/narnet_mac.sv
// Shared signed multiply-accumulate with clear, bias load, saturated
// N-bit fixed-point result and clip flag.
module narnet_mac import narnet_pkg::*; #(
  parameter int unsigned N    = 16,
  parameter int unsigned Q    = 10,
  parameter int unsigned AccW = 37
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                load,
  input  logic                en,
  input  logic signed [N-1:0] a,
  input  logic signed [N-1:0] b,
  input  logic signed [N-1:0] bias,
  output logic signed [N-1:0] y,
  output logic                clip
);

  logic signed [AccW-1:0] acc_q;
  logic signed [2*N-1:0]  prod;
  logic signed [MaxW-1:0] ext;
  logic signed [MaxW-1:0] sat_val;

  assign prod = (2*N)'(a) * (2*N)'(b);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc_q <= '0;
    end else if (load) begin
      acc_q <= AccW'(bias) <<< Q;
    end else if (en) begin
      acc_q <= acc_q + AccW'(prod);
    end
  end

  assign ext     = MaxW'(acc_q);
  assign sat_val = sat_shift(ext, N, Q);
  assign y       = sat_val[N-1:0];
  assign clip    = (sat_val != (ext >>> Q));

endmodule

// File: rtl/narnet_core.sv
// NARX-style tapped-delay neural net: one hidden tanh layer and a linear
// output, evaluated sequentially on a single shared MAC.
module narnet_core import narnet_pkg::*; #(
  parameter int unsigned        N    = 16,
  parameter int unsigned        Q    = 10,
  parameter int unsigned        D    = 16,
  parameter int unsigned        H    = 5,
  parameter logic signed [N-1:0] INIT = 16'sd384,
  localparam int unsigned       AW   = $clog2(H*D + 2*H + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [N-1:0] x_in,
  input  logic                mode,
  output logic [AW-1:0]       w_addr,
  input  logic signed [N-1:0] w_data,
  output logic signed [N-1:0] t_addr,
  input  logic signed [N-1:0] t_data,
  output logic signed [N-1:0] y_out,
  output logic                out_valid,
  output logic                sat
);

  localparam int unsigned AccW = 2*N + $clog2(D + 1);
  localparam int unsigned KW   = $clog2(((D > H) ? D : H) + 2);
  localparam int unsigned HW   = (H > 1) ? $clog2(H) : 1;
  localparam int unsigned PW   = $clog2(D);
  localparam int unsigned SW   = $clog2(2*D);

  state_e              state_q;
  logic [KW-1:0]       k_q;
  logic [HW-1:0]       h_q;
  logic [PW-1:0]       wptr_q;
  logic signed [N-1:0] push_q;
  logic                hclip_q;
  logic signed [N-1:0] taps_q [D];
  logic signed [N-1:0] hid_q  [H];

  logic                mac_clr, mac_load, mac_en, mac_clip;
  logic signed [N-1:0] mac_b, mac_y;
  logic [SW-1:0]       tap_sum;
  logic [PW-1:0]       tap_idx;
  logic [HW-1:0]       hidx;

  assign in_ready = (state_q == StIdle);

  // Tap d = k_q-1 sits just behind the write pointer: wptr-1-d modulo D.
  assign tap_sum = SW'(wptr_q) + SW'(D) - SW'(k_q);
  assign tap_idx = (tap_sum >= SW'(D)) ? PW'(tap_sum - SW'(D)) : PW'(tap_sum);
  assign hidx    = HW'(k_q - KW'(2));
  assign mac_clr = (state_q == StIdle);

  always_comb begin
    mac_load = 1'b0;
    mac_en   = 1'b0;
    mac_b    = '0;
    case (state_q)
      StL1: begin
        mac_load = (k_q == '0);
        mac_en   = (k_q != '0) && (k_q <= KW'(D));
        mac_b    = taps_q[tap_idx];
      end
      StL2: begin
        mac_load = (k_q == KW'(1));
        mac_en   = (k_q >= KW'(2));
        mac_b    = hid_q[hidx];
      end
      default: ;
    endcase
  end

  narnet_mac #(.N(N), .Q(Q), .AccW(AccW)) u_mac (
    .clk  (clk),
    .rst  (rst),
    .clr  (mac_clr),
    .load (mac_load),
    .en   (mac_en),
    .a    (w_data),
    .b    (mac_b),
    .bias (w_data),
    .y    (mac_y),
    .clip (mac_clip)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      k_q       <= '0;
      h_q       <= '0;
      wptr_q    <= '0;
      push_q    <= '0;
      hclip_q   <= 1'b0;
      w_addr    <= '0;
      t_addr    <= '0;
      y_out     <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
      for (int i = 0; i < int'(D); i++) taps_q[i] <= INIT;
      for (int i = 0; i < int'(H); i++) hid_q[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state_q)
        StIdle: begin
          w_addr <= '0;
          if (in_valid) begin
            push_q  <= mode ? y_out : x_in;
            hclip_q <= 1'b0;
            state_q <= StPush;
          end
        end
        StPush: begin
          taps_q[wptr_q] <= push_q;
          wptr_q  <= (wptr_q == PW'(D - 1)) ? '0 : wptr_q + 1'b1;
          w_addr  <= AW'(w1_addr(0, 0, H, D));
          k_q     <= '0;
          h_q     <= '0;
          state_q <= StL1;
        end
        StL1: begin
          // Address leads the MAC by one cycle to cover the ROM latency.
          if (k_q <= KW'(D - 2)) w_addr <= AW'(w1_addr(32'(h_q), 32'(k_q) + 1, H, D));
          else if (k_q == KW'(D)) w_addr <= AW'(b1_addr(32'(h_q) + 1));
          else if (k_q == KW'(D + 1)) w_addr <= AW'(w1_addr(32'(h_q) + 1, 0, H, D));
          if (k_q == KW'(D + 1)) begin
            hid_q[h_q] <= mac_y;
            hclip_q    <= hclip_q | mac_clip;
            k_q        <= '0;
            if (h_q == HW'(H - 1)) begin
              h_q     <= '0;
              state_q <= StTanh;
            end else begin
              h_q <= h_q + 1'b1;
            end
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        StTanh: begin
          // LUT result for neuron j-1 lands while neuron j's address is issued.
          if (k_q == '0) begin
            t_addr <= hid_q[h_q];
            if (h_q != '0) hid_q[h_q - 1'b1] <= t_data;
            k_q <= KW'(1);
          end else begin
            k_q <= '0;
            if (h_q == HW'(H - 1)) begin
              h_q     <= '0;
              w_addr  <= AW'(b2_addr(H, D));
              state_q <= StL2;
            end else begin
              h_q <= h_q + 1'b1;
            end
          end
        end
        StL2: begin
          if (k_q == '0) hid_q[HW'(H - 1)] <= t_data;
          if (k_q < KW'(H)) w_addr <= AW'(w2_addr(32'(k_q), H, D));
          if (k_q == KW'(H + 1)) state_q <= StOut;
          else k_q <= k_q + 1'b1;
        end
        StOut: begin
          y_out     <= mac_y;
          sat       <= hclip_q | mac_clip;
          out_valid <= 1'b1;
          w_addr    <= '0;
          t_addr    <= '0;
          k_q       <= '0;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_narnet_core.sv
// Directed bench for narnet_core: registered weight ROM and identity tanh
// LUT models, latency, saturation, closed-loop, abort and streaming checks.
module tb_narnet_core;

  localparam int N   = 16;
  localparam int NH  = 5;
  localparam int ND  = 16;
  localparam int AW  = $clog2(NH*ND + 2*NH + 1);
  localparam int Lat = NH*ND + 5*NH + 4;
  localparam int RomSz = NH*ND + 2*NH + 1;

  logic                clk = 1'b0;
  logic                rst, in_valid, mode, in_ready, out_valid, sat;
  logic signed [N-1:0] x_in, w_data, t_addr, t_data, y_out;
  logic [AW-1:0]       w_addr;
  logic signed [N-1:0] rom [RomSz];

  int checks = 0;
  int errors = 0;

  narnet_core dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .mode      (mode),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .t_addr    (t_addr),
    .t_data    (t_data),
    .y_out     (y_out),
    .out_valid (out_valid),
    .sat       (sat)
  );

  always #5 clk = ~clk;

  // One-cycle-latency ROM and an identity tanh table.
  always @(posedge clk) begin
    w_data <= rom[w_addr];
    t_data <= t_addr;
  end

  function automatic int w1(input int h, input int d);
    return NH + h*ND + d;
  endfunction
  function automatic int w2(input int h);
    return NH + NH*ND + h;
  endfunction
  localparam int B2 = NH + NH*ND + NH;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < RomSz; i++) rom[i] = '0;
  endtask

  task automatic identity_rom();
    clear_rom();
    rom[w1(0, 0)] = 16'sd1024;
    rom[w2(0)]    = 16'sd1024;
  endtask

  // Called at #1 after an edge with the DUT idle.
  task automatic infer(input string tag, input logic signed [N-1:0] x, input logic m,
                       input int exp_y, input int exp_sat);
    int cyc;
    in_valid = 1'b1;
    x_in     = x;
    mode     = m;
    @(posedge clk); #1;
    in_valid = 1'b0;
    x_in     = -x - 16'sd7;
    mode     = ~m;
    check({tag, "_busy"}, int'(in_ready), 0);
    cyc = 0;
    while (!out_valid && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_lat"}, cyc, Lat);
    check({tag, "_y"}, int'(y_out), exp_y);
    check({tag, "_sat"}, int'(sat), exp_sat);
    @(posedge clk); #1;
    check({tag, "_pulse"}, int'(out_valid), 0);
  endtask

  initial begin
    int   seen, prev_acc, naccept, npulse;
    logic will;

    rst = 1'b1; in_valid = 1'b0; x_in = '0; mode = 1'b0;
    clear_rom();
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    check("rst_y", int'(y_out), 0);
    check("rst_sat", int'(sat), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_ready", int'(in_ready), 1);
    check("rst_waddr", int'(w_addr), 0);
    check("rst_taddr", int'(t_addr), 0);

    // Only the output bias is set: 512 passes straight through.
    clear_rom();
    rom[B2] = 16'sd512;
    infer("bias", 16'sd100, 1'b0, 512, 0);

    // Unity weight on tap 0 of neuron 0 and on W2[0].
    identity_rom();
    infer("id_pos", 16'sd300, 1'b0, 300, 0);
    infer("id_neg", -16'sd200, 1'b0, -200, 0);

    // Closed loop: y_out is fed back, x_in ignored.
    infer("cl_0", 16'sd300, 1'b0, 300, 0);
    infer("cl_1", -16'sd7777, 1'b1, 300, 0);
    infer("cl_2", 16'sd1234, 1'b1, 300, 0);
    infer("cl_3", -16'sd1, 1'b1, 300, 0);

    // Hidden sums clip to 32767, then 32767*32767>>10 clips again.
    clear_rom();
    for (int h = 0; h < NH; h++)
      for (int d = 0; d < ND; d++) rom[w1(h, d)] = 16'sd32767;
    rom[w2(0)] = 16'sd32767;
    infer("sat_pos", 16'sd32767, 1'b0, 32767, 1);
    // Negated W1: hidden clips to -32768, output -32768*32767>>10 clips low.
    for (int h = 0; h < NH; h++)
      for (int d = 0; d < ND; d++) rom[w1(h, d)] = -16'sd32767;
    infer("sat_neg", 16'sd32767, 1'b0, -32768, 1);

    identity_rom();
    infer("sat_clr", 16'sd100, 1'b0, 100, 0);

    // Abort 50 cycles into an inference.
    in_valid = 1'b1; x_in = 16'sd999; mode = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (50) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_ready", int'(in_ready), 1);
    check("abort_y", int'(y_out), 0);
    seen = 0;
    repeat (150) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("abort_no_valid", seen, 0);
    // After reset every older tap holds INIT, so tap 5 yields 384.
    clear_rom();
    rom[w1(0, 5)] = 16'sd1024;
    rom[w2(0)]    = 16'sd1024;
    infer("abort_init", 16'sd777, 1'b0, 384, 0);

    // in_valid held high: accepts every Lat+1 cycles, one pulse each.
    identity_rom();
    in_valid = 1'b1; x_in = 16'sd50; mode = 1'b0;
    prev_acc = -1; naccept = 0; npulse = 0;
    for (int e = 1; e <= 3*(Lat + 1); e++) begin
      will = in_valid && in_ready;
      @(posedge clk); #1;
      if (will) begin
        if (prev_acc >= 0) check("hold_gap", e - prev_acc, Lat + 1);
        prev_acc = e;
        naccept++;
      end
      if (out_valid) begin
        npulse++;
        check("hold_lat", e - prev_acc, Lat);
        check("hold_y", int'(y_out), 50);
      end
      if (e == 3*(Lat + 1)) in_valid = 1'b0;
    end
    check("hold_accepts", naccept, 3);
    check("hold_pulses", npulse, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
